// File: rtl/sync_ram_be_pkg.sv
// -----------------------------------------------------------------------------
// sync_ram_be_pkg
//   Shared definitions for the byte-enable synchronous RAM family.
//   - rdw_mode_e     : read-during-write behaviour selector
//   - merge_lanes()  : combine an old and a new word under a per-lane write
//                      enable; also used by the AHB SSRAM bridge
// -----------------------------------------------------------------------------
package sync_ram_be_pkg;

  typedef enum int unsigned {
    RDW_WRITE_FIRST = 0,
    RDW_READ_FIRST  = 1,
    RDW_NO_CHANGE   = 2
  } rdw_mode_e;

  // Upper bounds for merge_lanes(); callers zero-extend into these widths.
  localparam int unsigned MAX_WORD_WIDTH = 256;
  localparam int unsigned MAX_LANES      = 256;

  // Bit b belongs to lane b / byte_width; written lanes take new_w.
  function automatic logic [MAX_WORD_WIDTH-1:0] merge_lanes(
    input logic [MAX_WORD_WIDTH-1:0] old_w,
    input logic [MAX_WORD_WIDTH-1:0] new_w,
    input logic [MAX_LANES-1:0]      lane_we,
    input int unsigned               byte_width
  );
    logic [MAX_WORD_WIDTH-1:0] m;
    m = old_w;
    for (int unsigned b = 0; b < MAX_WORD_WIDTH; b++) begin
      if (lane_we[8'(b / byte_width)]) begin
        m[8'(b)] = new_w[8'(b)];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_ram_be_out_pipe.sv
// -----------------------------------------------------------------------------
// ram_out_pipe
//   Reset-clearable data + valid register chain of STAGES (>= 1) stages.
//   Ports:
//     clk_i    rising-edge clock
//     rst_i    synchronous active-high clear of every stage
//     data_i   data entering the chain
//     valid_i  qualifier entering the chain
//     data_o   data after STAGES cycles
//     valid_o  qualifier after STAGES cycles
// -----------------------------------------------------------------------------
module ram_out_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  localparam int unsigned TOTAL = STAGES * WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("ram_out_pipe: STAGES must be at least 1");
  end

  // Newest entry at the bottom, oldest at the top; the concatenation is
  // truncated so the oldest entry drops off each cycle.
  logic [TOTAL-1:0]  data_q,  data_d;
  logic [STAGES-1:0] valid_q, valid_d;

  always_comb begin
    data_d  = TOTAL'({data_q, data_i});
    valid_d = STAGES'({valid_q, valid_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q[TOTAL-1 -: WIDTH];
  assign valid_o = valid_q[STAGES-1];

endmodule

// File: rtl/sync_ram_be.sv
// -----------------------------------------------------------------------------
// sync_ram_be
//   Single-port synchronous RAM with per-byte-lane write enables, selectable
//   read-during-write behaviour and an optional output register.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset of the output path only
//                 (also blocks writes in that cycle; array is never cleared)
//     en          port enable
//     we          per-lane write enable (NB = WORD_WIDTH/BYTE_WIDTH lanes)
//     addr        word address
//     din         write data
//     dout        read data, latency 1 + OUT_REG
//     dout_valid  dout carries the result of an access issued L cycles ago
// -----------------------------------------------------------------------------
module sync_ram_be
  import sync_ram_be_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] we,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [WORD_WIDTH-1:0]            din,
  output logic [WORD_WIDTH-1:0]            dout,
  output logic                             dout_valid
);

  localparam int unsigned NB    = WORD_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam rdw_mode_e   Mode  = rdw_mode_e'(RDW_MODE);

  if (BYTE_WIDTH == 0) begin : g_bad_byte
    $error("sync_ram_be: BYTE_WIDTH must be non-zero");
  end else if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sync_ram_be: WORD_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (WORD_WIDTH > MAX_WORD_WIDTH) begin : g_too_wide
    $error("sync_ram_be: WORD_WIDTH exceeds MAX_WORD_WIDTH");
  end
  if (RDW_MODE > 2) begin : g_bad_rdw
    $error("sync_ram_be: RDW_MODE must be 0, 1 or 2");
  end
  if (OUT_REG > 1) begin : g_bad_outreg
    $error("sync_ram_be: OUT_REG must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Storage: one array per lane so each lane's write enable stays independent.
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] old_word;
  logic [WORD_WIDTH-1:0] merged_word;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [BYTE_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst && en && we[i]) begin
        mem_q[addr] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign old_word[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_q[addr];
  end

  assign merged_word = WORD_WIDTH'(merge_lanes(MAX_WORD_WIDTH'(old_word),
                                               MAX_WORD_WIDTH'(din),
                                               MAX_LANES'(we),
                                               BYTE_WIDTH));

  // ---------------------------------------------------------------------------
  // Stage 1: read result. Data holds when idle or in NO_CHANGE writes.
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] data1_q, data1_d;
  logic                  valid1_q, valid1_d;

  always_comb begin
    data1_d  = data1_q;
    valid1_d = 1'b0;
    if (en) begin
      if (we == '0) begin
        data1_d  = old_word;
        valid1_d = 1'b1;
      end else begin
        case (Mode)
          RDW_WRITE_FIRST: begin
            data1_d  = merged_word;
            valid1_d = 1'b1;
          end
          RDW_READ_FIRST: begin
            data1_d  = old_word;
            valid1_d = 1'b1;
          end
          default: begin
            data1_d  = data1_q;
            valid1_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      data1_q  <= data1_d;
      valid1_q <= valid1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stage 2
  // ---------------------------------------------------------------------------
  if (OUT_REG == 1) begin : g_out_reg
    ram_out_pipe #(
      .WIDTH  (WORD_WIDTH),
      .STAGES (1)
    ) u_out_pipe (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (data1_q),
      .valid_i (valid1_q),
      .data_o  (dout),
      .valid_o (dout_valid)
    );
  end else begin : g_no_out_reg
    assign dout       = data1_q;
    assign dout_valid = valid1_q;
  end

  // ---------------------------------------------------------------------------
  // Simulation hooks for monitors
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  event read;
  event write;

  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (we == '0) begin
        -> read;
      end else begin
        -> write;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_ram_be.sv
module tb_sync_ram_be;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [3:0]  we  = '0;
  logic [9:0]  addr = '0;
  logic [31:0] din  = '0;

  logic [31:0] dout [NI];
  logic        dv   [NI];

  always #5 clk = ~clk;

  // Instance map: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE (all 1-cycle, 10-bit addr),
  //               3 WRITE_FIRST with output register and 4-bit addr.
  sync_ram_be #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .RDW_MODE(0), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout[0]), .dout_valid(dv[0]));
  sync_ram_be #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .RDW_MODE(1), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout[1]), .dout_valid(dv[1]));
  sync_ram_be #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .RDW_MODE(2), .OUT_REG(0)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout[2]), .dout_valid(dv[2]));
  sync_ram_be #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(1)) u_wfr (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr[3:0]), .din(din),
    .dout(dout[3]), .dout_valid(dv[3]));

  // Reference model: per-instance word arrays plus the result of each access,
  // delayed by the instance's latency.
  int unsigned mode_t [NI] = '{0, 1, 2, 0};
  int unsigned lat_t  [NI] = '{1, 1, 1, 2};
  logic [9:0]  amask  [NI] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h00F};

  logic [31:0] mem_m  [NI][1024];
  logic [31:0] held_m [NI];
  logic [31:0] res_d  [NI][2];   // [0] latest access result, [1] the one before
  logic        res_v  [NI][2];
  logic [31:0] pre    [1024];    // preload values as driven

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      logic [9:0]  a;
      logic [31:0] old_w, new_w, r_d;
      logic        r_v;
      if (rst) begin
        held_m[i]   = '0;
        res_d[i][0] = '0; res_d[i][1] = '0;
        res_v[i][0] = 1'b0; res_v[i][1] = 1'b0;
      end else begin
        a     = addr & amask[i];
        old_w = mem_m[i][a];
        new_w = old_w;
        for (int j = 0; j < 4; j++) if (we[j]) new_w[j*8 +: 8] = din[j*8 +: 8];
        r_d = held_m[i];
        r_v = 1'b0;
        if (en) begin
          if (we == 4'b0) begin
            r_d = old_w; r_v = 1'b1;
          end else begin
            mem_m[i][a] = new_w;
            if (mode_t[i] == 0) begin r_d = new_w; r_v = 1'b1; end
            else if (mode_t[i] == 1) begin r_d = old_w; r_v = 1'b1; end
          end
        end
        held_m[i]   = r_d;
        res_d[i][1] = res_d[i][0]; res_v[i][1] = res_v[i][0];
        res_d[i][0] = r_d;         res_v[i][0] = r_v;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] w,
                      input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; en = e; we = w; addr = a; din = d;
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("model_dout%0d", i), dout[i], res_d[i][lat_t[i]-1]);
        check($sformatf("model_valid%0d", i), {31'b0, dv[i]}, {31'b0, res_v[i][lat_t[i]-1]});
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [3:0]  w;

    // Power-on reset
    step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    check("por_dout3", dout[3], 32'h0);
    check("por_valid3", {31'b0, dv[3]}, 32'h0);

    // Preload every word so later reads are fully defined
    chk_en = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      v = $urandom;
      pre[a] = v;
      step(1'b0, 1'b1, 4'hF, 10'(a), v);
    end
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    chk_en = 1'b1;

    // 1: writes under reset are suppressed
    step(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    step(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    check("rst_dout0", dout[0], 32'h0);
    check("rst_valid0", {31'b0, dv[0]}, 32'h0);
    check("rst_dout3", dout[3], 32'h0);
    check("rst_valid3", {31'b0, dv[3]}, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd5, 32'h0);
    check("rst_nowrite", dout[0], pre[5]);

    // 2: byte lanes
    step(1'b0, 1'b1, 4'hF, 10'd3, 32'h11223344);
    step(1'b0, 1'b1, 4'b0101, 10'd3, 32'hAABBCCDD);
    step(1'b0, 1'b1, 4'h0, 10'd3, 32'h0);
    check("lanes_wf", dout[0], 32'h11BB33DD);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    check("lanes_reg", dout[3], 32'h11BB33DD);
    check("idle_hold", dout[0], 32'h11BB33DD);
    check("idle_valid", {31'b0, dv[0]}, 32'h0);

    // 3: read-during-write modes
    step(1'b0, 1'b1, 4'hF, 10'd7, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd9, 32'h0);
    step(1'b0, 1'b1, 4'b0011, 10'd7, 32'hCAFEF00D);
    check("rdw_wf_data", dout[0], 32'h0000F00D);
    check("rdw_wf_valid", {31'b0, dv[0]}, 32'h1);
    check("rdw_rf_data", dout[1], 32'h0);
    check("rdw_rf_valid", {31'b0, dv[1]}, 32'h1);
    check("rdw_nc_data", dout[2], pre[9]);
    check("rdw_nc_valid", {31'b0, dv[2]}, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd7, 32'h0);
    check("b2b_read", dout[2], 32'h0000F00D);

    // 4: two-cycle latency, valid high for exactly three cycles
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd1, 32'h0);
    check("lat_v0", {31'b0, dv[3]}, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd2, 32'h0);
    check("lat_d1", dout[3], pre[1009]);
    check("lat_v1", {31'b0, dv[3]}, 32'h1);
    step(1'b0, 1'b1, 4'h0, 10'd3, 32'h0);
    check("lat_d2", dout[3], pre[1010]);
    check("lat_v2", {31'b0, dv[3]}, 32'h1);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    check("lat_d3", dout[3], 32'h11BB33DD);
    check("lat_v3", {31'b0, dv[3]}, 32'h1);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    check("lat_v4", {31'b0, dv[3]}, 32'h0);

    // 5: top and bottom address of the 4-bit instance, plus wrap of upper bits
    step(1'b0, 1'b1, 4'hF, 10'd15, 32'h5A5A5A5A);
    step(1'b0, 1'b1, 4'hF, 10'd0, 32'hA5A5A5A5);
    step(1'b0, 1'b1, 4'h0, 10'd15, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd0, 32'h0);
    check("wrap_top", dout[3], 32'h5A5A5A5A);
    step(1'b0, 1'b1, 4'h0, 10'h3EF, 32'h0);
    check("wrap_bot", dout[3], 32'hA5A5A5A5);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    check("wrap_alias", dout[3], 32'h5A5A5A5A);

    // 6: reset while a read is inside the output register
    step(1'b0, 1'b1, 4'h0, 10'd15, 32'h0);
    step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    check("midrst_d0", dout[3], 32'h0);
    check("midrst_v0", {31'b0, dv[3]}, 32'h0);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    check("midrst_d1", dout[3], 32'h0);
    check("midrst_v1", {31'b0, dv[3]}, 32'h0);

    // Random traffic, addresses biased toward a small window for RDW hits
    for (int n = 0; n < 3000; n++) begin
      w = 4'($urandom);
      if ($urandom_range(0, 2) == 0) w = 4'h0;
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           w,
           ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom),
           $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
